// File: rtl/mult_datapath.sv
// Datapath for the sequential multiplier: operand capture, nibble partial products and shift-accumulate.
// Define MULT_DP_RESULT_REG_EN to add a result register that holds the last finished product.
module mult_datapath #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_a,
   input  logic                  start,
   input  logic [DATA_W-1:0]     dataa,
   input  logic [DATA_W-1:0]     datab,
   input  logic [1:0]            input_sel,
   input  logic [1:0]            shift_sel,
   input  logic                  clk_ena,
   input  logic                  sclr_n,
   input  logic                  done,
   output logic [1:0]            count,
   output logic [DATA_W-1:0]     partial,
   output logic [2*DATA_W-1:0]   product8x8
);

   localparam int HALF   = DATA_W / 2;
   localparam int PROD_W = 2 * DATA_W;

   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [1:0]        count_q, count_d;
   logic [PROD_W-1:0] acc_q, acc_d;
   logic [HALF-1:0]   nib_a, nib_b;
   logic [DATA_W-1:0] partial_w;
   logic [PROD_W-1:0] partial_ext;
   logic [PROD_W-1:0] shifted;

   always_comb begin
      opa_d   = opa_q;
      opb_d   = opb_q;
      count_d = count_q + 2'd1;
      if (start) begin
         opa_d   = dataa;
         opb_d   = datab;
         count_d = 2'd0;
      end
   end

   // input_sel[1] picks the multiplicand nibble, input_sel[0] the multiplier nibble
   always_comb begin
      nib_a = input_sel[1] ? opa_q[DATA_W-1:HALF] : opa_q[HALF-1:0];
      nib_b = input_sel[0] ? opb_q[DATA_W-1:HALF] : opb_q[HALF-1:0];
   end

   assign partial_w   = DATA_W'(nib_a) * DATA_W'(nib_b);
   assign partial_ext = PROD_W'(partial_w);

   always_comb begin
      case (shift_sel)
         2'b01:   shifted = partial_ext << HALF;
         2'b10:   shifted = partial_ext << DATA_W;
         default: shifted = partial_ext;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      if (clk_ena) begin
         acc_d = sclr_n ? (acc_q + shifted) : shifted;
      end
   end

   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         opa_q   <= '0;
         opb_q   <= '0;
         count_q <= '0;
         acc_q   <= '0;
      end else begin
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         count_q <= count_d;
         acc_q   <= acc_d;
      end
   end

`ifdef MULT_DP_RESULT_REG_EN
   logic [PROD_W-1:0] res_q, res_d;

   // The final step's sum is folded in directly so res lands on the same edge as acc
   always_comb begin
      res_d = res_q;
      if (done) begin
         res_d = clk_ena ? (acc_q + shifted) : acc_q;
      end
   end

   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         res_q <= '0;
      end else begin
         res_q <= res_d;
      end
   end

   assign product8x8 = res_q;
`else
   logic unused_done;
   assign unused_done = done;
   assign product8x8  = acc_q;
`endif

   assign count   = count_q;
   assign partial = partial_w;

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Arithmetic datapath and step counter for the sequential 8x8 multiplier; sits directly downstream of mult_control.
- Consumes input_sel, shift_sel, clk_ena, sclr_n and done from the control FSM, and feeds count back to it.
- Forms the product as four 4x4 nibble partial products, each shifted and accumulated into a 16-bit register over four enabled cycles.

Parameters:
- DATA_W, 8, operand width. Must be even; HALF = DATA_W/2 is the nibble width; product width is 2*DATA_W.

Ports:
- clk  in  1  system clock, rising-edge active
- reset_a  in  1  asynchronous active-low reset
- start  in  1  start pulse from the top level; captures operands and clears the counter
- dataa  in  DATA_W  multiplicand
- datab  in  DATA_W  multiplier
- input_sel  in  2  nibble-pair select from mult_control
- shift_sel  in  2  partial-product shift select from mult_control
- clk_ena  in  1  accumulator update enable from mult_control
- sclr_n  in  1  active-low accumulator restart from mult_control
- done  in  1  operation-complete flag from mult_control
- count  out  2  step counter to mult_control
- partial  out  DATA_W  current unshifted 4x4 partial product (combinational, debug)
- product8x8  out  2*DATA_W  multiplication result

Behaviour:
- Reset (reset_a=0, asynchronous): opa, opb, acc, count, result register all 0; product8x8=0; partial=0.
- Operand capture:
  - On a clk edge with start=1: opa<=dataa, opb<=datab.
  - Otherwise opa/opb hold. Operand changes after the start cycle must not affect the running product.
- Counter:
  - start=1 at an edge: count<=0.
  - Otherwise count<=count+1 every edge, wrapping 3->0.
  - start has priority over increment.
- Nibble mux (combinational, on opa/opb):
  - input_sel 00: opa[lo] x opb[lo]
  - input_sel 01: opa[lo] x opb[hi]
  - input_sel 10: opa[hi] x opb[lo]
  - input_sel 11: opa[hi] x opb[hi]
- partial: unsigned HALF x HALF product, DATA_W bits wide, no truncation.
- Shifter: zero-extend partial to 2*DATA_W, then:
  - shift_sel 00: shift by 0
  - shift_sel 01: shift left by HALF
  - shift_sel 10: shift left by DATA_W
  - shift_sel 11: treated as shift by 0
- Accumulator (synchronous update):
  - clk_ena=0: acc holds, regardless of sclr_n.
  - clk_ena=1, sclr_n=0: acc<=shifted (fresh operation; previous content discarded).
  - clk_ena=1, sclr_n=1: acc<=acc+shifted, modulo 2^(2*DATA_W). Cannot overflow for a legal four-step sequence.
- Latency:
  - The accumulator reflects a step one edge after that step's controls are sampled.
  - The full product is valid in acc on the edge after the fourth enabled step.
- product8x8: equals acc (see Optional Feature).
- start during an operation: operands reload and count restarts at the next edge. acc is untouched until the control asserts sclr_n=0 with clk_ena=1.
- Reset mid-operation: all state clears immediately; no partial result survives.

Optional Feature:
- Macro: MULT_DP_RESULT_REG_EN
- Defined:
  - Adds result register res, reset 0.
  - res<=acc+shifted on an edge where done=1 and clk_ena=1; otherwise res<=acc on an edge where done=1; otherwise res holds.
  - product8x8=res, so the output stays stable through the next multiplication until done asserts again.
- Undefined:
  - No result register; product8x8=acc, so intermediate sums are visible during operation.
- Both builds: identical count and partial behaviour.

Test Plan:
- Reset: hold reset_a=0 mid-clock with nonzero acc/count -> count=0, product8x8=0x0000 immediately, without waiting for a clock edge.
- Basic product: start with a=0x12, b=0x34, then four steps (sel/shift/sclr_n = 00/00/0, 01/01/1, 10/01/1, 11/10/1, clk_ena=1) -> acc after each step = 0x0008, 0x0068, 0x00A8, 0x03A8.
- Max operands: a=0xFF, b=0xFF over the same four steps -> product8x8=0xFE01; partial=0xE1 at every step.
- Operand isolation: start with a=0x0F, b=0x0F, then change dataa/datab to 0xAA on the following cycle -> result is 0x00E1.
- Counter: start=1 for one edge, then free-run -> count sequence 0,1,2,3,0; start reasserted at count=2 -> count=0 on the next edge.
- clk_ena gating: clk_ena=0 for two cycles between steps 2 and 3 -> acc holds 0x0068 (a=0x12, b=0x34), final 0x03A8. With MULT_DP_RESULT_REG_EN: product8x8 keeps the previous result 0xFE01 until done.
